regfile_sb: RTL and testbench

//   32 x 32-bit integer register file with write-port bypass and a per-register

---
 rtl/regfile_sb.sv | 89 ++++++++
 tb/tb_regfile_sb.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// 32 x 32-bit register file with same-cycle write bypass and a per-register
// busy scoreboard that stalls decode while a source awaits its producer.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              busy1,
  output logic              busy2,
  output logic              stall
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              wr_en;
  logic              set_en;

  assign wr_en  = we && (waddr != '0);
  assign set_en = issue_en && (issue_rd != '0) && !stall;

  // Clear first so that a newer producer issuing this cycle keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[waddr] = 1'b0;
    end
    if (set_en) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_en) begin
        regs_q[waddr] <= wdata;
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    busy1  = 1'b0;
    if (!rst && re1 && (raddr1 != '0)) begin
      if (we && (waddr == raddr1)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = regs_q[raddr1];
        busy1  = busy_q[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    busy2  = 1'b0;
    if (!rst && re2 && (raddr2 != '0)) begin
      if (we && (waddr == raddr2)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = regs_q[raddr2];
        busy2  = busy_q[raddr2];
      end
    end
  end

  assign stall = busy1 | busy2;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_sb;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        busy1;
  logic        busy2;
  logic        stall;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic        b1;
    logic        b2;
    logic        st;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_sb #(
    .DATA_W(32),
    .ADDR_W(5),
    .NREG  (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re1     (re1),
    .raddr1  (raddr1),
    .rdata1  (rdata1),
    .re2     (re2),
    .raddr2  (raddr2),
    .rdata2  (rdata2),
    .issue_en(issue_en),
    .issue_rd(issue_rd),
    .busy1   (busy1),
    .busy2   (busy2),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %08h, expected %08h", name, field, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the negedge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, "rdata1", rdata1, e.r1);
      check(e.name, "rdata2", rdata2, e.r2);
      check(e.name, "busy1", {31'd0, busy1}, {31'd0, e.b1});
      check(e.name, "busy2", {31'd0, busy2}, {31'd0, e.b2});
      check(e.name, "stall", {31'd0, stall}, {31'd0, e.st});
    end
  end

  task automatic drive(input string name, input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ie, input logic [4:0] ird,
                       input logic e1, input logic [4:0] a1, input logic e2,
                       input logic [4:0] a2, input logic [31:0] x1, input logic [31:0] x2,
                       input logic xb1, input logic xb2, input logic xst);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    we       = w;
    waddr    = wa;
    wdata    = wd;
    issue_en = ie;
    issue_rd = ird;
    re1      = e1;
    raddr1   = a1;
    re2      = e2;
    raddr2   = a2;
    e.name = name;
    e.r1   = x1;
    e.r2   = x2;
    e.b1   = xb1;
    e.b2   = xb2;
    e.st   = xst;
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; issue_en = 1'b0; issue_rd = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

    //    name            rst we wa  wdata         ie rd  e1 a1  e2 a2  rdata1        rdata2   b1 b2 st
    drive("rst_gate",     1, 1, 5,  32'h00000077, 1, 5,  1, 5,  1, 5,  32'h0,        32'h0,   0, 0, 0);
    drive("post_rst",     0, 0, 0,  32'h0,        0, 0,  1, 5,  0, 0,  32'h0,        32'h0,   0, 0, 0);
    drive("bypass",       0, 1, 3,  32'hDEADBEEF, 0, 0,  1, 3,  0, 0,  32'hDEADBEEF, 32'h0,   0, 0, 0);
    drive("stored",       0, 0, 0,  32'h0,        0, 0,  1, 3,  1, 3,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
    drive("wr_x0",        0, 1, 0,  32'h00001234, 0, 0,  1, 0,  1, 0,  32'h0,        32'h0,   0, 0, 0);
    drive("rd_x0",        0, 0, 0,  32'h0,        0, 0,  1, 0,  1, 0,  32'h0,        32'h0,   0, 0, 0);
    drive("re_off",       0, 0, 0,  32'h0,        0, 0,  0, 3,  1, 3,  32'h0,        32'hDEADBEEF, 0, 0, 0);
    drive("issue7",       0, 0, 0,  32'h0,        1, 7,  0, 0,  0, 0,  32'h0,        32'h0,   0, 0, 0);
    drive("busy7_stall",  0, 0, 0,  32'h0,        1, 8,  0, 0,  1, 7,  32'h0,        32'h0,   0, 1, 1);
    drive("issue_ignored",0, 0, 0,  32'h0,        0, 0,  1, 8,  1, 7,  32'h0,        32'h0,   0, 1, 1);
    drive("wb7_bypass",   0, 1, 7,  32'h00000055, 0, 0,  0, 0,  1, 7,  32'h0,        32'h55,  0, 0, 0);
    drive("wb7_stored",   0, 0, 0,  32'h0,        0, 0,  0, 0,  1, 7,  32'h0,        32'h55,  0, 0, 0);
    drive("set_clr_same", 0, 1, 7,  32'h00000066, 1, 7,  1, 7,  0, 0,  32'h66,       32'h0,   0, 0, 0);
    drive("set_wins",     0, 0, 0,  32'h0,        0, 0,  1, 7,  0, 0,  32'h66,       32'h0,   1, 0, 1);
    drive("wb7_again",    0, 1, 7,  32'h00000067, 0, 0,  1, 7,  0, 0,  32'h67,       32'h0,   0, 0, 0);
    drive("set9_wr9",     0, 1, 9,  32'h000000AA, 1, 9,  0, 0,  1, 9,  32'h0,        32'hAA,  0, 0, 0);
    drive("busy9",        0, 0, 0,  32'h0,        0, 0,  1, 9,  0, 0,  32'hAA,       32'h0,   1, 0, 1);
    drive("rst_with_we",  1, 1, 9,  32'h000000BB, 0, 0,  1, 9,  0, 0,  32'h0,        32'h0,   0, 0, 0);
    drive("after_rst9",   0, 0, 0,  32'h0,        0, 0,  1, 9,  0, 0,  32'h0,        32'h0,   0, 0, 0);
    drive("after_rst3",   0, 0, 0,  32'h0,        0, 0,  1, 3,  1, 9,  32'h0,        32'h0,   0, 0, 0);
    drive("issue10",      0, 0, 0,  32'h0,        1, 10, 0, 0,  0, 0,  32'h0,        32'h0,   0, 0, 0);
    drive("busy_re_mask", 0, 0, 0,  32'h0,        0, 0,  0, 10, 1, 10, 32'h0,        32'h0,   0, 1, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
